ex_vector_sequencer: RTL and testbench



---
 rtl/ex_vector_sequencer_pkg.sv | 40 ++++
 rtl/ex_vector_sequencer_if.sv | 49 ++++
 rtl/ex_vector_sequencer_lane_alu.sv | 32 +++
 rtl/ex_vector_sequencer.sv | 154 +++++++++++++++
 tb/tb_ex_vector_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vec_pkg
// Description : Shared types for the vector execute path. The operation-type
//               and ALU-operation enums are also consumed by the decoder and
//               by the ID/EX pipeline register users.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

  // Operation class carried in ID/EX.
  typedef enum logic [1:0] {
    SCALAR = 2'b00,
    VV     = 2'b01,
    VS     = 2'b10,
    RSVD   = 2'b11
  } op_type_t;

  // Lane ALU function.
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_t;

  // Only vector-vector and vector-scalar operations are run by the sequencer.
  function automatic logic is_vector_op(input op_type_t t);
    return (t == VV) || (t == VS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : ex_vector_sequencer_if
// Description : Bundle between the ID/EX register / hazard logic and the
//               vector execute sequencer.
//   start_i      : ID/EX holds a valid operation
//   flush_i      : synchronous abort
//   OpType_i     : 00 scalar, 01 vector-vector, 10 vector-scalar, 11 reserved
//   ALUControl_i : 00 add, 01 sub, 10 and, 11 or
//   A3_i         : destination register
//   RD1_V_i/RD2_V_i : vector operands, RD2_S_i : scalar operand
//   stall_o      : hold IF/ID and ID/EX
//   busy_o       : sequencer is running beats
//   done_o       : one-cycle result-valid pulse
//   Result_V_o   : result vector, A3_o : its destination register
//   master = pipeline side, slave = sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_vector_sequencer_if #(
  parameter int N = 32,
  parameter int V = 20
);
  logic                start_i;
  logic                flush_i;
  logic [1:0]          OpType_i;
  logic [1:0]          ALUControl_i;
  logic [3:0]          A3_i;
  logic [V-1:0][N-1:0] RD1_V_i;
  logic [V-1:0][N-1:0] RD2_V_i;
  logic [N-1:0]        RD2_S_i;
  logic                stall_o;
  logic                busy_o;
  logic                done_o;
  logic [V-1:0][N-1:0] Result_V_o;
  logic [3:0]          A3_o;

  modport master (
    output start_i, flush_i, OpType_i, ALUControl_i, A3_i,
           RD1_V_i, RD2_V_i, RD2_S_i,
    input  stall_o, busy_o, done_o, Result_V_o, A3_o
  );

  modport slave (
    input  start_i, flush_i, OpType_i, ALUControl_i, A3_i,
           RD1_V_i, RD2_V_i, RD2_S_i,
    output stall_o, busy_o, done_o, Result_V_o, A3_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_vector_sequencer_lane_alu.sv
`default_nettype none
// ============================================================================
// Module      : vec_lane_alu
// Description : Combinational single-lane ALU. add/sub wrap modulo 2^N,
//               and/or are bitwise; no flags are produced.
//   op : ALU function, a/b : N-bit operands, y : N-bit result
// Revision    : 1.0 - initial release
// ============================================================================
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int N = 32
) (
  input  alu_op_t        op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   y
);

  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ex_vector_sequencer
// Description : Execute-stage vector sequencer. Latches a vector operation
//               from ID/EX, runs LANES lanes per beat for V/LANES beats,
//               stalls the pipeline front while doing so and then pulses
//               done_o with the complete result and its destination.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_vector_sequencer_if.slave (operation in, stall/result out)
// Revision    : 1.0 - initial release
// ============================================================================
module ex_vector_sequencer
  import vec_pkg::*;
#(
  parameter int N     = 32,
  parameter int V     = 20,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ex_vector_sequencer_if.slave  bus
);

  localparam int BEATS  = V / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LIDX_W = (V > 1) ? $clog2(V) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (V % LANES != 0) begin : g_lanes_check
    $error("ex_vector_sequencer: V must be a multiple of LANES");
  end

  seq_state_t          state;
  logic [BEAT_W-1:0]   beat;
  alu_op_t             alu_q;
  op_type_t            op_q;
  logic [3:0]          a3_q;
  logic [V-1:0][N-1:0] rd1_q;
  logic [V-1:0][N-1:0] rd2_q;
  logic [N-1:0]        rs_q;
  logic [V-1:0][N-1:0] result_q;
  logic [3:0]          a3_out_q;
  logic                busy_q;
  logic                done_q;

  op_type_t            op_in;
  logic                accept;
  logic [LIDX_W-1:0]   base;
  logic [LANES-1:0][N-1:0] lane_y;

  assign op_in = op_type_t'(bus.OpType_i);

  // A flush wins over a simultaneous start; start is only looked at when the
  // sequencer is free (IDLE, or DONE for back-to-back issue).
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start_i &&
                  is_vector_op(op_in) && !bus.flush_i;

  // Stall drops during the last beat so ID/EX advances at its end and the
  // next operation is already presented in the DONE cycle.
  assign bus.stall_o = accept || ((state == BUSY) && (beat != LAST_BEAT));

  // First lane handled in the current beat.
  assign base = LIDX_W'(beat) * LIDX_W'(LANES);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [LIDX_W-1:0] idx;
    logic [N-1:0]      a;
    logic [N-1:0]      b;

    assign idx = base + LIDX_W'(j);
    assign a   = rd1_q[idx];
    assign b   = (op_q == VS) ? rs_q : rd2_q[idx];

    vec_lane_alu #(.N(N)) u_alu (
      .op (alu_q),
      .a  (a),
      .b  (b),
      .y  (lane_y[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      alu_q    <= ADD;
      op_q     <= SCALAR;
      a3_q     <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      rs_q     <= '0;
      result_q <= '0;
      a3_out_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.flush_i) begin
      // Abort: results already written stay in place, nothing is signalled.
      state  <= IDLE;
      beat   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            alu_q  <= alu_op_t'(bus.ALUControl_i);
            op_q   <= op_in;
            a3_q   <= bus.A3_i;
            rd1_q  <= bus.RD1_V_i;
            rd2_q  <= bus.RD2_V_i;
            rs_q   <= bus.RD2_S_i;
            beat   <= '0;
            state  <= BUSY;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end

        BUSY: begin
          for (int j = 0; j < LANES; j++) begin
            result_q[base + LIDX_W'(j)] <= lane_y[j];
          end
          if (beat == LAST_BEAT) begin
            beat     <= '0;
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            a3_out_q <= a3_q;
          end else begin
            beat <= beat + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          beat   <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.Result_V_o = result_q;
  assign bus.A3_o       = a3_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_vector_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ex_vector_sequencer
// Description : Self-checking bench for ex_vector_sequencer. Expected results
//               come from a whole-vector reference function; timing
//               expectations come from the accept-relative cycle schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_vector_sequencer;
  localparam int N     = 32;
  localparam int V     = 20;
  localparam int LANES = 4;

  typedef logic [V-1:0][N-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_vector_sequencer_if #(.N(N), .V(V)) bus ();

  ex_vector_sequencer #(.N(N), .V(V), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t exp_result = '0;
  logic [3:0] exp_a3 = '0;

  // Reference: whole vector at once, straight from the operation definition.
  function automatic vec_t model_op(input logic [1:0] ot, input logic [1:0] alu,
                                    input vec_t a, input vec_t b, input logic [N-1:0] s);
    vec_t r;
    logic [N-1:0] rhs;
    r = '0;
    for (int l = 0; l < V; l++) begin
      rhs = (ot == 2'b10) ? s : b[l];
      case (alu)
        2'd0:    r[l] = a[l] + rhs;
        2'd1:    r[l] = a[l] - rhs;
        2'd2:    r[l] = a[l] & rhs;
        default: r[l] = a[l] | rhs;
      endcase
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < V; l++) v[l] = $urandom;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] ot, input logic [1:0] alu, input logic [3:0] a3,
                          input vec_t a, input vec_t b, input logic [N-1:0] s);
    bus.start_i      = 1'b1;
    bus.OpType_i     = ot;
    bus.ALUControl_i = alu;
    bus.A3_i         = a3;
    bus.RD1_V_i      = a;
    bus.RD2_V_i      = b;
    bus.RD2_S_i      = s;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", bus.stall_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done_o); end
    n_tests++; if (bus.Result_V_o !== vec_t'(0)) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.Result_V_o); end
    n_tests++; if (bus.A3_o !== 4'h0) begin n_fail++; $display("FAIL reset_a3 got %h exp 0", bus.A3_o); end
  endtask

  task automatic test_vv_add();
    vec_t a, b, e;
    logic [3:0] a3;
    for (int l = 0; l < V; l++) begin
      a[l] = N'(l);
      b[l] = N'(100 * l);
      e[l] = N'(101 * l);
    end
    a3 = 4'(9);
    next_cycle();
    drive_op(2'b01, 2'b00, a3, a, b, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++; if (bus.stall_o !== (k <= 4)) begin n_fail++; $display("FAIL vv_add_stall k=%0d got %b exp %b", k, bus.stall_o, (k <= 4)); end
      n_tests++; if (bus.busy_o !== (k >= 1 && k <= 5)) begin n_fail++; $display("FAIL vv_add_busy k=%0d got %b exp %b", k, bus.busy_o, (k >= 1 && k <= 5)); end
      n_tests++; if (bus.done_o !== (k == 6)) begin n_fail++; $display("FAIL vv_add_done k=%0d got %b exp %b", k, bus.done_o, (k == 6)); end
      if (k == 6) begin
        n_tests++; if (bus.Result_V_o !== e) begin n_fail++; $display("FAIL vv_add_result got %h exp %h", bus.Result_V_o, e); end
        n_tests++; if (bus.A3_o !== a3) begin n_fail++; $display("FAIL vv_add_a3 got %h exp %h", bus.A3_o, a3); end
      end
      next_cycle();
      bus.start_i = 1'b0;
    end
    exp_result = e;
    exp_a3 = a3;
  endtask

  task automatic test_vs();
    logic [1:0]   alus [2];
    logic [N-1:0] av   [2];
    logic [N-1:0] sv   [2];
    logic [N-1:0] ev   [2];
    vec_t a, e;
    alus[0] = 2'b01; av[0] = 32'd5;         sv[0] = 32'd7;         ev[0] = 32'hFFFF_FFFE;
    alus[1] = 2'b10; av[1] = 32'hF0F0_F0F0; sv[1] = 32'h0FF0_0FF0; ev[1] = 32'h00F0_00F0;
    for (int c = 0; c < 2; c++) begin
      for (int l = 0; l < V; l++) begin a[l] = av[c]; e[l] = ev[c]; end
      next_cycle();
      drive_op(2'b10, alus[c], 4'(3 + c), a, rand_vec(), sv[c]);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        n_tests++; if (bus.done_o !== (k == 6)) begin n_fail++; $display("FAIL vs_done case=%0d k=%0d got %b exp %b", c, k, bus.done_o, (k == 6)); end
        if (k == 6) begin
          n_tests++; if (bus.Result_V_o !== e) begin n_fail++; $display("FAIL vs_result case=%0d got %h exp %h", c, bus.Result_V_o, e); end
          n_tests++; if (bus.A3_o !== 4'(3 + c)) begin n_fail++; $display("FAIL vs_a3 case=%0d got %h exp %h", c, bus.A3_o, 4'(3 + c)); end
        end
        next_cycle();
        bus.start_i = 1'b0;
      end
      exp_result = e;
      exp_a3 = 4'(3 + c);
    end
  endtask

  task automatic test_back_to_back();
    vec_t a1, b1, a2, b2, e1, e2;
    logic [N-1:0] s2;
    logic [3:0] a31, a32;
    logic x_stall, x_busy, x_done;
    a1 = rand_vec(); b1 = rand_vec(); a2 = rand_vec(); b2 = rand_vec(); s2 = $urandom;
    a31 = 4'($urandom_range(0, 15)); a32 = a31 + 4'd1;
    e1 = model_op(2'b01, 2'b01, a1, b1, '0);
    e2 = model_op(2'b10, 2'b11, a2, b2, s2);
    next_cycle();
    drive_op(2'b01, 2'b01, a31, a1, b1, '0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      x_stall = (k <= 4) || (k >= 6 && k <= 10);
      x_busy  = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
      x_done  = (k == 6) || (k == 12);
      n_tests++; if (bus.stall_o !== x_stall) begin n_fail++; $display("FAIL b2b_stall k=%0d got %b exp %b", k, bus.stall_o, x_stall); end
      n_tests++; if (bus.busy_o !== x_busy) begin n_fail++; $display("FAIL b2b_busy k=%0d got %b exp %b", k, bus.busy_o, x_busy); end
      n_tests++; if (bus.done_o !== x_done) begin n_fail++; $display("FAIL b2b_done k=%0d got %b exp %b", k, bus.done_o, x_done); end
      if (k == 6) begin
        n_tests++; if (bus.Result_V_o !== e1) begin n_fail++; $display("FAIL b2b_result1 got %h exp %h", bus.Result_V_o, e1); end
        n_tests++; if (bus.A3_o !== a31) begin n_fail++; $display("FAIL b2b_a3_1 got %h exp %h", bus.A3_o, a31); end
      end
      if (k == 12) begin
        n_tests++; if (bus.Result_V_o !== e2) begin n_fail++; $display("FAIL b2b_result2 got %h exp %h", bus.Result_V_o, e2); end
        n_tests++; if (bus.A3_o !== a32) begin n_fail++; $display("FAIL b2b_a3_2 got %h exp %h", bus.A3_o, a32); end
      end
      next_cycle();
      if (k + 1 == 6) drive_op(2'b10, 2'b11, a32, a2, b2, s2);
      else bus.start_i = 1'b0;
    end
    exp_result = e2;
    exp_a3 = a32;
  endtask

  task automatic test_flush();
    vec_t a, b, e_new, old;
    logic ok_hi, ok_lo;
    a = rand_vec(); b = rand_vec();
    e_new = model_op(2'b01, 2'b00, a, b, '0);
    old = exp_result;
    next_cycle();
    drive_op(2'b01, 2'b00, exp_a3 + 4'd5, a, b, '0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        n_tests++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_stall_pre k=%0d got %b exp 1", k, bus.stall_o); end
      end else begin
        n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_stall_post k=%0d got %b exp 0", k, bus.stall_o); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy_post k=%0d got %b exp 0", k, bus.busy_o); end
      end
      n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL flush_done k=%0d got %b exp 0", k, bus.done_o); end
      next_cycle();
      bus.start_i = 1'b0;
      bus.flush_i = (k + 1 == 3);
    end
    ok_hi = 1'b1; ok_lo = 1'b1;
    for (int l = 12; l < V; l++) if (bus.Result_V_o[l] !== old[l]) ok_hi = 1'b0;
    for (int l = 0; l < 8; l++)  if (bus.Result_V_o[l] !== e_new[l]) ok_lo = 1'b0;
    n_tests++; if (!ok_hi) begin n_fail++; $display("FAIL flush_lanes_12_19 got %h exp upper lanes of %h", bus.Result_V_o, old); end
    n_tests++; if (!ok_lo) begin n_fail++; $display("FAIL flush_lanes_0_7 got %h exp lower lanes of %h", bus.Result_V_o, e_new); end
    n_tests++; if (bus.A3_o !== exp_a3) begin n_fail++; $display("FAIL flush_a3 got %h exp %h", bus.A3_o, exp_a3); end
    // Flush and start together: flush wins.
    drive_op(2'b01, 2'b00, 4'd1, a, b, '0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_prio_stall got %b exp 0", bus.stall_o); end
    next_cycle();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_prio_busy got %b exp 0", bus.busy_o); end
    for (int l = 0; l < 8; l++) exp_result[l] = e_new[l];
  endtask

  task automatic test_reserved();
    logic [1:0] ots [2];
    ots[0] = 2'b00; ots[1] = 2'b11;
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      drive_op(ots[c], 2'b00, 4'hF, rand_vec(), rand_vec(), $urandom);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rsvd_stall op=%b k=%0d got %b exp 0", ots[c], k, bus.stall_o); end
        n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rsvd_busy op=%b k=%0d got %b exp 0", ots[c], k, bus.busy_o); end
        n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL rsvd_done op=%b k=%0d got %b exp 0", ots[c], k, bus.done_o); end
        next_cycle();
      end
      bus.start_i = 1'b0;
    end
    n_tests++; if (bus.A3_o !== exp_a3) begin n_fail++; $display("FAIL rsvd_a3 got %h exp %h", bus.A3_o, exp_a3); end
  endtask

  task automatic test_async_reset();
    vec_t a, b, e;
    logic [3:0] a3;
    next_cycle();
    drive_op(2'b01, 2'b10, 4'd7, rand_vec(), rand_vec(), '0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.start_i = 1'b0;
    end
    // Now in cycle 4 (beat 3); pull reset between edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL arst_stall got %b exp 0", bus.stall_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", bus.busy_o); end
    n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b exp 0", bus.done_o); end
    n_tests++; if (bus.Result_V_o !== vec_t'(0)) begin n_fail++; $display("FAIL arst_result got %h exp 0", bus.Result_V_o); end
    n_tests++; if (bus.A3_o !== 4'h0) begin n_fail++; $display("FAIL arst_a3 got %h exp 0", bus.A3_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_result = '0;
    exp_a3 = '0;
    a = rand_vec(); b = rand_vec(); a3 = 4'd12;
    e = model_op(2'b01, 2'b01, a, b, '0);
    next_cycle();
    drive_op(2'b01, 2'b01, a3, a, b, '0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++; if (bus.done_o !== (k == 6)) begin n_fail++; $display("FAIL arst_recover_done k=%0d got %b exp %b", k, bus.done_o, (k == 6)); end
      if (k == 6) begin
        n_tests++; if (bus.Result_V_o !== e) begin n_fail++; $display("FAIL arst_recover_result got %h exp %h", bus.Result_V_o, e); end
        n_tests++; if (bus.A3_o !== a3) begin n_fail++; $display("FAIL arst_recover_a3 got %h exp %h", bus.A3_o, a3); end
      end
      next_cycle();
      bus.start_i = 1'b0;
    end
    exp_result = e;
    exp_a3 = a3;
  endtask

  task automatic test_random();
    vec_t a, b, e;
    logic [N-1:0] s;
    logic [1:0] ot, alu;
    logic [3:0] a3;
    int got;
    for (int t = 0; t < 10; t++) begin
      a = rand_vec(); b = rand_vec(); s = $urandom;
      ot  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      alu = 2'($urandom_range(0, 3));
      a3  = 4'($urandom_range(0, 15));
      e   = model_op(ot, alu, a, b, s);
      repeat ($urandom_range(0, 2)) next_cycle();
      next_cycle();
      drive_op(ot, alu, a3, a, b, s);
      got = -1;
      for (int k = 0; k < 20 && got < 0; k++) begin
        @(negedge clk);
        if (bus.done_o === 1'b1) got = k;
        next_cycle();
        bus.start_i = 1'b0;
      end
      n_tests++; if (got != 6) begin n_fail++; $display("FAIL rand_latency op=%0d got %0d exp 6", t, got); end
      n_tests++; if (bus.Result_V_o !== e) begin n_fail++; $display("FAIL rand_result op=%0d ot=%b alu=%b got %h exp %h", t, ot, alu, bus.Result_V_o, e); end
      n_tests++; if (bus.A3_o !== a3) begin n_fail++; $display("FAIL rand_a3 op=%0d got %h exp %h", t, bus.A3_o, a3); end
      exp_result = e;
      exp_a3 = a3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.start_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.OpType_i     = 2'b00;
    bus.ALUControl_i = 2'b00;
    bus.A3_i         = 4'h0;
    bus.RD1_V_i      = '0;
    bus.RD2_V_i      = '0;
    bus.RD2_S_i      = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_vv_add();
    test_vs();
    test_back_to_back();
    test_flush();
    test_reserved();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
